// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: fetch FSM states, the canonical NOP encoding
// and the fetch fault-cause codes.
package rv32i_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Wait counter for the instruction-memory handshake. Counts REQ cycles and
// flags expiry on the LIMIT-th cycle without an acknowledge.
// Only present when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  // Expiry is reported during the last allowed wait cycle so the FSM can
  // leave REQ on that edge.
  assign expired = enable && (count == 8'(LIMIT - 1));

  // Count enabled cycles; restart whenever the FSM is outside REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && !expired) begin
      count <= count + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// Multi-cycle RV32I instruction fetch: architectural PC, instruction
// register and a single req/ack read per fetch.
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch with cause 10
// after TIMEOUT_CYCLES unacknowledged REQ cycles.
module instr_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [31:0] pc_next,
  input  logic        fault_clr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_code,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_instr,
  output logic [31:0] pc_plus4,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 2..255");
  end

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  eff_addr;
  logic         misaligned;
  logic         timeout_hit;

  // A same-cycle pc_load redirects the fetch to the new target.
  assign eff_addr   = pc_load ? pc_next : pc;
  assign misaligned = (eff_addr[1:0] != 2'b00);
  assign pc_plus4   = pc_instr + 32'd4;

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != FETCH_REQ),
    .enable (state == FETCH_REQ),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; an ack in the expiry cycle still completes the fetch.
  always_comb begin
    state_next = state;
    case (state)
      FETCH_IDLE:  if (fetch_req) state_next = misaligned ? FETCH_FAULT : FETCH_REQ;
      FETCH_REQ:   begin
        if (imem_ack)         state_next = FETCH_IDLE;
        else if (timeout_hit) state_next = FETCH_FAULT;
      end
      FETCH_FAULT: if (fault_clr) state_next = FETCH_IDLE;
      default:     state_next = FETCH_IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    imem_req = (state == FETCH_REQ);
    busy     = (state == FETCH_REQ);
    fault    = (state == FETCH_FAULT);
  end

  // PC, fetch address, IR and fault cause; pc_load works in every state and
  // never touches the in-flight fetch address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      imem_addr   <= RESET_PC;
      pc_instr    <= RESET_PC;
      instr_code  <= INSTR_NOP;
      instr_valid <= 1'b0;
      fault_cause <= FAULT_NONE;
    end else begin
      instr_valid <= 1'b0;
      if (pc_load) pc <= pc_next;
      case (state)
        FETCH_IDLE: begin
          if (fetch_req) begin
            if (misaligned) fault_cause <= FAULT_MISALIGN;
            else            imem_addr   <= eff_addr;
          end
        end
        FETCH_REQ: begin
          if (imem_ack) begin
            instr_code  <= imem_rdata;
            pc_instr    <= imem_addr;
            instr_valid <= 1'b1;
          end else if (timeout_hit) begin
            fault_cause <= FAULT_TIMEOUT;
          end
        end
        FETCH_FAULT: if (fault_clr) fault_cause <= FAULT_NONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. Expected IR/pc_instr pairs are
// queued when an ack is driven and retired by a monitor on instr_valid.
module tb_instr_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic        fault_clr = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr_code;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_instr;
  logic [31:0] pc_plus4;
  logic        busy;
  logic        fault;
  logic [1:0]  fault_cause;

  int   total = 0;
  int   passed = 0;
  exp_t sb[$];

  instr_fetch_unit #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .pc_load    (pc_load),
    .pc_next    (pc_next),
    .fault_clr  (fault_clr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_code (instr_code),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_instr   (pc_instr),
    .pc_plus4   (pc_plus4),
    .busy       (busy),
    .fault      (fault),
    .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every instr_valid pulse must match the oldest entry.
  always @(negedge clk) begin
    if (!reset && instr_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_valid got instr=%h pc_instr=%h, want no pulse", instr_code, pc_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (instr_code !== e.instr || pc_instr !== e.pc)
          $display("FAIL sb_fetch got instr=%h pc=%h, want instr=%h pc=%h", instr_code, pc_instr, e.instr, e.pc);
        else passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++; if (imem_req !== 1'b0) $display("FAIL rst_imem_req got %b want 0", imem_req); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    total++; if (fault !== 1'b0 || fault_cause !== 2'b00) $display("FAIL rst_fault got %b/%b want 0/00", fault, fault_cause); else passed++;
    total++; if (instr_code !== NOP) $display("FAIL rst_instr got %h want %h", instr_code, NOP); else passed++;
    total++; if (pc !== 32'h0 || pc_instr !== 32'h0 || imem_addr !== 32'h0) $display("FAIL rst_pcs got %h/%h/%h want 0", pc, pc_instr, imem_addr); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", instr_valid); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    total++; if (imem_req !== 1'b1 || busy !== 1'b1) $display("FAIL zw_req got req=%b busy=%b want 1/1", imem_req, busy); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL zw_addr got %h want 0", imem_addr); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    sb.push_back('{32'h0050_0093, 32'h0});
    tick();
    imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b1) $display("FAIL zw_valid got %b want 1", instr_valid); else passed++;
    total++; if (pc_plus4 !== 32'h4) $display("FAIL zw_plus4 got %h want 4", pc_plus4); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL zw_req_drop got %b want 0", imem_req); else passed++;
    tick();
    total++; if (instr_valid !== 1'b0) $display("FAIL zw_pulse got %b want 0", instr_valid); else passed++;
  endtask

  task automatic test_wait_states();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL ws_hold%0d got req=%b addr=%h want 1/0", i, imem_req, imem_addr); else passed++;
      if (i == 0) begin pc_load = 1'b1; pc_next = 32'h100; end
      tick();
      pc_load = 1'b0;
    end
    total++; if (pc !== 32'h100) $display("FAIL ws_pc got %h want 100", pc); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'h00A0_0113;
    sb.push_back('{32'h00A0_0113, 32'h0});
    tick();
    imem_ack = 1'b0;
    total++; if (pc_instr !== 32'h0 || pc !== 32'h100) $display("FAIL ws_after got pc_instr=%h pc=%h want 0/100", pc_instr, pc); else passed++;
    tick();
  endtask

  task automatic test_load_fetch(input logic [31:0] target, input logic [31:0] word, input logic [31:0] plus4);
    pc_load = 1'b1; pc_next = target; fetch_req = 1'b1;
    tick();
    pc_load = 1'b0; fetch_req = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== target) $display("FAIL lf_addr got req=%b addr=%h want 1/%h", imem_req, imem_addr, target); else passed++;
    imem_ack = 1'b1; imem_rdata = word;
    sb.push_back('{word, target});
    tick();
    imem_ack = 1'b0;
    total++; if (pc_plus4 !== plus4) $display("FAIL lf_plus4 got %h want %h", pc_plus4, plus4); else passed++;
    tick();
  endtask

  task automatic test_misaligned();
    pc_load = 1'b1; pc_next = 32'h22;
    tick();
    pc_load = 1'b0; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    total++; if (fault !== 1'b1 || fault_cause !== 2'b01) $display("FAIL mis_fault got %b/%b want 1/01", fault, fault_cause); else passed++;
    total++; if (imem_req !== 1'b0 || busy !== 1'b0) $display("FAIL mis_noreq got req=%b busy=%b want 0/0", imem_req, busy); else passed++;
    total++; if (instr_code !== 32'h0000_006F || pc_instr !== 32'hFFFF_FFFC) $display("FAIL mis_ir got %h/%h want 6f/fffffffc", instr_code, pc_instr); else passed++;
    fetch_req = 1'b1; pc_load = 1'b1; pc_next = 32'h80;
    tick();
    fetch_req = 1'b0; pc_load = 1'b0;
    total++; if (fault !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h80) $display("FAIL mis_sticky got fault=%b req=%b pc=%h want 1/0/80", fault, imem_req, pc); else passed++;
    fault_clr = 1'b1; fetch_req = 1'b1;
    tick();
    fault_clr = 1'b0; fetch_req = 1'b0;
    total++; if (fault !== 1'b0 || fault_cause !== 2'b00) $display("FAIL mis_clr got %b/%b want 0/00", fault, fault_cause); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL mis_clr_wins got req=%b want 0", imem_req); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b0 || instr_code !== 32'h0000_006F) $display("FAIL idle_ack got valid=%b instr=%h want 0/6f", instr_valid, instr_code); else passed++;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    n = 0;
`ifdef FETCH_TIMEOUT_EN
    while (imem_req === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    total++; if (n !== 4) $display("FAIL to_cycles got %0d want 4", n); else passed++;
    total++; if (fault !== 1'b1 || fault_cause !== 2'b10) $display("FAIL to_cause got %b/%b want 1/10", fault, fault_cause); else passed++;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    total++; if (fault !== 1'b0 || fault_cause !== 2'b00) $display("FAIL to_clr got %b/%b want 0/00", fault, fault_cause); else passed++;
`else
    for (int i = 0; i < 100; i++) begin
      if (imem_req === 1'b1 && imem_addr === 32'h80) n++;
      tick();
    end
    total++; if (n !== 100) $display("FAIL to_wait got %0d want 100", n); else passed++;
    total++; if (fault !== 1'b0 || fault_cause !== 2'b00) $display("FAIL to_nofault got %b/%b want 0/00", fault, fault_cause); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'h0000_0517;
    sb.push_back('{32'h0000_0517, 32'h80});
    tick();
    imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b1) $display("FAIL to_late_ack got %b want 1", instr_valid); else passed++;
`endif
    tick();
  endtask

  task automatic test_reset_mid_req();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    total++; if (imem_req !== 1'b1) $display("FAIL rmr_req got %b want 1", imem_req); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0 || busy !== 1'b0) $display("FAIL rmr_drop got req=%b busy=%b want 0/0", imem_req, busy); else passed++;
    total++; if (instr_code !== NOP || pc !== 32'h0) $display("FAIL rmr_vals got instr=%h pc=%h want 13/0", instr_code, pc); else passed++;
    @(negedge clk);
    reset = 1'b0;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b0 || instr_code !== NOP) $display("FAIL rmr_stray got valid=%b instr=%h want 0/13", instr_valid, instr_code); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_load_fetch(32'h0000_0040, 32'h0400_0293, 32'h0000_0044);
    test_load_fetch(32'hFFFF_FFFC, 32'h0000_006F, 32'h0000_0000);
    test_misaligned();
    test_timeout();
    test_reset_mid_req();
    tick();
    total++; if (sb.size() != 0) $display("FAIL sb_drain got %0d pending want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multi-cycle RV32I instruction fetch stage. Holds the architectural PC and the instruction register (IR). Issues one request/acknowledge read to instruction memory per fetch. Sits directly upstream of the control unit: `instr_code` drives the decoder, and the unit loads the datapath-computed next PC (branch/jal/jalr mux result) when the control unit asserts `pc_load`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `TIMEOUT_CYCLES`, 16, maximum wait for `imem_ack` (used only with the macro enabled; range 2..255).
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_req`  in  1  single-cycle pulse: fetch the instruction at the current PC.
- `pc_load`  in  1  load `pc_next` into PC.
- `pc_next`  in  32  next PC from datapath.
- `fault_clr`  in  1  clear sticky fault and return to IDLE.
- `imem_req`  out  1  memory read request.
- `imem_addr`  out  32  memory read address (word-aligned).
- `imem_ack`  in  1  read data valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr_code`  out  32  instruction register.
- `instr_valid`  out  1  one-cycle pulse when IR updated.
- `pc`  out  32  current PC register.
- `pc_instr`  out  32  PC of the instruction held in IR (for AUIPC/branch/JAL targets).
- `pc_plus4`  out  32  `pc_instr + 4` (JAL/JALR link value).
- `busy`  out  1  high in REQ.
- `fault`  out  1  sticky fault flag.
- `fault_cause`  out  2  00 none, 01 misaligned PC, 10 fetch timeout.

## Operation
- FSM states: IDLE, REQ, FAULT.
- **IDLE**
  - On `fetch_req`, the effective address is `pc_next` if `pc_load` is asserted in the same cycle; otherwise it is `pc`.
  - If `addr[1:0] != 0`, go to FAULT with cause 01.
  - Otherwise latch `addr` into the fetch-address register and go to REQ.
- **REQ**
  - `imem_req` = 1 and `imem_addr` = the latched fetch address, held stable until acknowledged.
  - On `imem_ack`: IR ← `imem_rdata`, `pc_instr` ← fetch address, `instr_valid` pulses the next cycle, then go to IDLE.
  - `fetch_req` in REQ is ignored.
- **FAULT**
  - `imem_req` = 0 and `fault` = 1. `fault_cause` holds its value.
  - IR and `pc_instr` are unchanged.
  - `fault_clr` returns to IDLE and clears `fault` and `fault_cause`.
  - `fetch_req` is ignored until the fault is cleared.
- **PC register**
  - `pc_load` updates `pc` in any state. No alignment check is made at load time; the check happens at fetch.
  - A load during REQ does not disturb the in-flight address.
  - The PC never auto-increments. The datapath supplies `pc_plus4` through `pc_next`.
- **Arithmetic:** `pc_plus4` is 32-bit modulo. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- **Reset values (async):**
  - state IDLE
  - `pc` = `pc_instr` = `imem_addr` = `RESET_PC`
  - `instr_code` = 32'h0000_0013 (NOP)
  - `instr_valid`, `imem_req`, `busy`, `fault` = 0; `fault_cause` = 00
- **Reset mid-REQ:** the request is dropped immediately (asynchronous). A late `imem_ack` after reset is ignored because the state is IDLE.

## Timing
- **Cycle 0:** `fetch_req` sampled.
- **Cycle 1:** `imem_req` high (registered).
- **Cycle k ≥ 1:** `imem_ack` sampled.
- **Cycle k+1:** `instr_code` and `pc_instr` valid, `instr_valid` = 1 for exactly one cycle.
- Zero-wait memory (ack in cycle 1) gives 2-cycle fetch latency.
- `imem_ack` outside REQ has no effect.
- Misaligned fault: `fault` is high at cycle 1. No memory request is issued.
- `fault_clr` and `fetch_req` in the same cycle: the clear wins and the fetch is dropped.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - An 8-bit wait counter runs in REQ.
  - If `TIMEOUT_CYCLES` REQ cycles pass without `imem_ack`, deassert `imem_req` and go to FAULT with cause 10.
  - An ack arriving in the same cycle as expiry counts as success.
- Undefined: REQ waits indefinitely, cause 10 is never produced, and the counter is absent.

## Structure
- Shared package `rv32i_pkg` holds:
  - the fetch state enum
  - the `INSTR_NOP` constant
  - the fault-cause codes (`FAULT_NONE`, `FAULT_MISALIGN`, `FAULT_TIMEOUT`)
- Sub-module `fetch_timeout_counter` (clear / enable / expired), instantiated only under `FETCH_TIMEOUT_EN`.

## Test plan
- **Reset then fetch, zero-wait memory:** reset, `fetch_req`, ack in cycle 1 with rdata 32'h0050_0093 → `instr_valid` in cycle 2, `instr_code` 32'h0050_0093, `pc_instr` 0, `pc_plus4` 4.
- **Wait states:** ack delayed 3 cycles → `imem_req`/`imem_addr` stable for 3 cycles; meanwhile `pc_load` 32'h100 → `pc` = 32'h100, `imem_addr` unchanged, `pc_instr` = old address.
- **Same-cycle load+fetch:** `pc_load` 32'h40 with `fetch_req` → `imem_addr` 32'h40 in cycle 1.
- **Misaligned fetch:** `pc_load` 32'h22 then `fetch_req` → `fault` = 1, cause 01, no `imem_req`; `fault_clr` → IDLE, `fault` = 0.
- **Timeout (`FETCH_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4):** never ack → `imem_req` drops after 4 REQ cycles, cause 10; with the macro undefined, `imem_req` stays high for 100 cycles.
- **Reset mid-REQ, then stray ack:** `imem_req` = 0 immediately; `instr_code` = NOP; the stray ack produces no `instr_valid`.
